mem_wb_stage: RTL and testbench

//  Parametrised MEM->WB pipeline stage of the 5-step CPU. Non-memory instructions pass to WB
//  in one cycle. LOAD/STORE run a req/ack data-memory transaction with any number of wait

---
 rtl/mem_wb_stage_pkg.sv | 21 ++
 rtl/mem_req_fsm.sv | 112 +++++++++++
 rtl/mem_wb_stage.sv | 104 ++++++++++
 tb/tb_mem_wb_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM->WB stage: memory opcodes, the CPU execute phase
// and the request FSM state encoding.
package mem_wb_stage_pkg;

    localparam int OPW = 5;

    localparam logic [OPW-1:0] OP_LOAD  = 5'b01000;
    localparam logic [OPW-1:0] OP_STORE = 5'b01001;

    localparam logic EXEC = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_fsm_e;

    function automatic logic is_mem_op(input logic [OPW-1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// Data-memory request engine: IDLE/WAIT FSM, req/ack interface registers, kill flag
// and, when MEM_TIMEOUT_EN is defined, the WAIT-state timeout counter.
module mem_req_fsm
    import mem_wb_stage_pkg::*;
#(
    parameter int DW          = 16,
    parameter int IW          = 16,
    parameter int AW          = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          state,
    input  logic [IW-1:0] mem_ir,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] st_data,
    input  logic          flush,
    output logic          d_req,
    output logic          d_we,
    output logic [AW-1:0] d_addr,
    output logic [DW-1:0] d_dataout,
    input  logic [DW-1:0] d_datain,
    input  logic          d_ack,
    output logic          accept,
    output logic          busy,
    output logic          done,
    output logic          done_kill,
    output logic          abort,
    output logic [IW-1:0] done_ir,
    output logic [DW-1:0] done_data,
    output logic          mem_err
);

    mem_fsm_e       fsm_q, fsm_d;
    logic [OPW-1:0] op;
    logic           kill_q;
    logic [IW-1:0]  ir_q;

    assign op = mem_ir[IW-1 -: OPW];

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        fsm_d     = fsm_q;
        busy      = (fsm_q == WAIT);
        accept    = (fsm_q == IDLE) && (state == EXEC) && mem_valid && !flush && is_mem_op(op);
        done      = busy && d_ack;
        done_kill = kill_q || flush;
        done_ir   = ir_q;
        done_data = d_we ? d_dataout : d_datain;
        case (fsm_q)
            IDLE: if (accept) fsm_d = WAIT;
            WAIT: if (d_ack || abort) fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
        if (reset) fsm_q <= IDLE;
        else       fsm_q <= fsm_d;
    end

    // A flush during WAIT only marks the result dead; the bus transaction always finishes.
    always_ff @(posedge clock) begin
        if (reset) begin
            d_req     <= 1'b0;
            d_we      <= 1'b0;
            d_addr    <= '0;
            d_dataout <= '0;
            ir_q      <= '0;
            kill_q    <= 1'b0;
        end else if (accept) begin
            d_req     <= 1'b1;
            d_we      <= (op == OP_STORE);
            d_addr    <= mem_addr;
            d_dataout <= st_data;
            ir_q      <= mem_ir;
            kill_q    <= 1'b0;
        end else if (busy) begin
            if (d_ack || abort) d_req  <= 1'b0;
            if (flush)          kill_q <= 1'b1;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wait_cnt_q;
    logic          mem_err_q;

    // An ack arriving on the last allowed WAIT cycle still completes normally.
    assign abort   = busy && !d_ack && (wait_cnt_q == CW'(TIMEOUT_CYC - 1));
    assign mem_err = mem_err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            mem_err_q <= abort;
            if (accept)    wait_cnt_q <= '0;
            else if (busy) wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign abort   = 1'b0;
    assign mem_err = 1'b0;
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: WB result registers and upstream stall around mem_req_fsm.
// Optional WAIT timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DW          = 16,
    parameter int IW          = 16,
    parameter int AW          = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          state,
    input  logic [IW-1:0] mem_ir,
    input  logic          mem_valid,
    input  logic [DW-1:0] reg_C,
    input  logic [DW-1:0] st_data,
    input  logic          flush,
    output logic          d_req,
    output logic          d_we,
    output logic [AW-1:0] d_addr,
    output logic [DW-1:0] d_dataout,
    input  logic [DW-1:0] d_datain,
    input  logic          d_ack,
    output logic          mem_stall,
    output logic [IW-1:0] wb_ir,
    output logic [DW-1:0] reg_C1,
    output logic          wb_valid,
    output logic          mem_err
);

    logic          accept;
    logic          busy;
    logic          done;
    logic          done_kill;
    logic          abort;
    logic [IW-1:0] done_ir;
    logic [DW-1:0] done_data;

    mem_req_fsm #(
        .DW          (DW),
        .IW          (IW),
        .AW          (AW),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_req (
        .clock     (clock),
        .reset     (reset),
        .state     (state),
        .mem_ir    (mem_ir),
        .mem_valid (mem_valid),
        .mem_addr  (reg_C[AW-1:0]),
        .st_data   (st_data),
        .flush     (flush),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_dataout (d_dataout),
        .d_datain  (d_datain),
        .d_ack     (d_ack),
        .accept    (accept),
        .busy      (busy),
        .done      (done),
        .done_kill (done_kill),
        .abort     (abort),
        .done_ir   (done_ir),
        .done_data (done_data),
        .mem_err   (mem_err)
    );

    assign mem_stall = accept || (busy && !d_ack);

    // While a transaction is outstanding the CPU phase is ignored; reg_C1 only moves on a real result.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_ir    <= '0;
            reg_C1   <= '0;
            wb_valid <= 1'b0;
        end else if (busy) begin
            if (done) begin
                if (done_kill) begin
                    wb_ir    <= '0;
                    wb_valid <= 1'b0;
                end else begin
                    wb_ir    <= done_ir;
                    reg_C1   <= done_data;
                    wb_valid <= 1'b1;
                end
            end else if (abort) begin
                wb_ir    <= '0;
                wb_valid <= 1'b0;
            end
        end else if (state == EXEC) begin
            if (flush || !mem_valid || accept) begin
                wb_ir    <= '0;
                wb_valid <= 1'b0;
            end else begin
                wb_ir    <= mem_ir;
                reg_C1   <= reg_C;
                wb_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases pinned to literals, then random
// traffic compared every cycle against a transaction-level model.
module tb_mem_wb_stage;

    localparam int DW = 16;
    localparam int IW = 16;
    localparam int AW = 8;
    localparam int TO = 15;

    localparam logic [IW-1:0] IR_ADD   = 16'h0800;
    localparam logic [IW-1:0] IR_LOAD  = 16'h4000;
    localparam logic [IW-1:0] IR_STORE = 16'h4800;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          state = 1'b0;
    logic [IW-1:0] mem_ir = '0;
    logic          mem_valid = 1'b0;
    logic [DW-1:0] reg_C = '0;
    logic [DW-1:0] st_data = '0;
    logic          flush = 1'b0;
    logic [DW-1:0] d_datain = '0;
    logic          d_ack = 1'b0;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_dataout;
    logic          mem_stall;
    logic [IW-1:0] wb_ir;
    logic [DW-1:0] reg_C1;
    logic          wb_valid;
    logic          mem_err;

    int tests = 0;
    int fails = 0;

    mem_wb_stage #(.DW(DW), .IW(IW), .AW(AW), .TIMEOUT_CYC(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .state     (state),
        .mem_ir    (mem_ir),
        .mem_valid (mem_valid),
        .reg_C     (reg_C),
        .st_data   (st_data),
        .flush     (flush),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_dataout (d_dataout),
        .d_datain  (d_datain),
        .d_ack     (d_ack),
        .mem_stall (mem_stall),
        .wb_ir     (wb_ir),
        .reg_C1    (reg_C1),
        .wb_valid  (wb_valid),
        .mem_err   (mem_err)
    );

    always #5 clock = ~clock;

    // Transaction-level model: one optional outstanding memory access plus the WB result.
    logic          m_busy, m_kill, m_store, m_req, m_wb_valid, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_sdata, m_reg_c1;
    logic [IW-1:0] m_ir, m_wb_ir;
    int            m_waited;
    int            ack_delay;

    function automatic logic op_is_mem(input logic [IW-1:0] ir);
        return (ir[IW-1:IW-5] == 5'h08) || (ir[IW-1:IW-5] == 5'h09);
    endfunction

    function automatic logic exp_stall();
        if (m_busy) return !d_ack;
        return state && mem_valid && !flush && op_is_mem(mem_ir);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_kill = 0; m_store = 0; m_req = 0; m_wb_valid = 0; m_err = 0;
        m_addr = '0; m_sdata = '0; m_reg_c1 = '0; m_ir = '0; m_wb_ir = '0;
        m_waited = 0; ack_delay = 0;
    endtask

    task automatic model_edge();
        m_err = 0;
        if (reset) begin
            model_reset();
        end else if (m_busy) begin
            if (flush) m_kill = 1;
            if (d_ack) begin
                m_busy = 0;
                m_req  = 0;
                if (m_kill) begin
                    m_wb_ir = '0; m_wb_valid = 0;
                end else begin
                    m_wb_ir = m_ir; m_wb_valid = 1;
                    m_reg_c1 = m_store ? m_sdata : d_datain;
                end
            end else begin
                m_waited++;
`ifdef MEM_TIMEOUT_EN
                if (m_waited == TO) begin
                    m_busy = 0; m_req = 0; m_err = 1;
                    m_wb_ir = '0; m_wb_valid = 0;
                end
`endif
            end
        end else if (state) begin
            if (flush || !mem_valid) begin
                m_wb_ir = '0; m_wb_valid = 0;
            end else if (op_is_mem(mem_ir)) begin
                m_busy = 1; m_kill = 0; m_req = 1; m_waited = 0;
                m_store = (mem_ir[IW-1:IW-5] == 5'h09);
                m_addr = reg_C[AW-1:0]; m_sdata = st_data; m_ir = mem_ir;
                m_wb_ir = '0; m_wb_valid = 0;
`ifdef MEM_TIMEOUT_EN
                ack_delay = ($urandom % 5 == 0) ? TO + 3 : int'($urandom_range(0, 4));
`else
                ack_delay = int'($urandom_range(0, 5));
`endif
            end else begin
                m_wb_ir = mem_ir; m_reg_c1 = reg_C; m_wb_valid = 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare_cycle();
        check("wb_ir", 32'(wb_ir), 32'(m_wb_ir));
        check("reg_C1", 32'(reg_C1), 32'(m_reg_c1));
        check("wb_valid", 32'(wb_valid), 32'(m_wb_valid));
        check("d_req", 32'(d_req), 32'(m_req));
        check("mem_err", 32'(mem_err), 32'(m_err));
        check("mem_stall", 32'(mem_stall), 32'(exp_stall()));
        if (m_req) begin
            check("d_we", 32'(d_we), 32'(m_store));
            check("d_addr", 32'(d_addr), 32'(m_addr));
            check("d_dataout", 32'(d_dataout), 32'(m_sdata));
        end
    endtask

    task automatic step();
        @(negedge clock);
        compare_cycle();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic st, input logic [IW-1:0] ir, input logic v,
                         input logic [DW-1:0] c, input logic [DW-1:0] sd,
                         input logic fl, input logic ack, input logic [DW-1:0] din);
        state = st; mem_ir = ir; mem_valid = v; reg_C = c; st_data = sd;
        flush = fl; d_ack = ack; d_datain = din;
    endtask

    initial begin
        int stall_cnt;
        logic [4:0] op;

        repeat (2) @(posedge clock);
        #1;
        model_reset();
        check("reset_wb_valid", 32'(wb_valid), 32'h0);
        check("reset_d_req", 32'(d_req), 32'h0);
        check("reset_wb_ir", 32'(wb_ir), 32'h0);
        reset = 1'b0;

        // ADD passes through in one cycle
        drive(1, IR_ADD, 1, 16'h1234, 16'h0, 0, 0, 16'h0);
        #1 check("add_no_stall", 32'(mem_stall), 32'h0);
        step();
        check("add_wb_ir", 32'(wb_ir), 32'h0800);
        check("add_reg_C1", 32'(reg_C1), 32'h1234);
        check("add_wb_valid", 32'(wb_valid), 32'h1);
        check("add_no_req", 32'(d_req), 32'h0);

        // LOAD with three wait states
        stall_cnt = 0;
        drive(1, IR_LOAD, 1, 16'h0042, 16'h0, 0, 0, 16'h0);
        #1 stall_cnt += int'(mem_stall);
        step();
        check("load_req", 32'(d_req), 32'h1);
        check("load_addr", 32'(d_addr), 32'h42);
        check("load_we", 32'(d_we), 32'h0);
        repeat (3) begin
            drive(1, IR_LOAD, 1, 16'h0042, 16'h0, 0, 0, 16'h0);
            #1 stall_cnt += int'(mem_stall);
            step();
        end
        drive(1, IR_LOAD, 1, 16'h0042, 16'h0, 0, 1, 16'hBEEF);
        #1 stall_cnt += int'(mem_stall);
        step();
        check("load_stall_cycles", 32'(stall_cnt), 32'd4);
        check("load_reg_C1", 32'(reg_C1), 32'hBEEF);
        check("load_wb_valid", 32'(wb_valid), 32'h1);
        check("load_wb_ir", 32'(wb_ir), 32'h4000);

        // STORE acked in the first WAIT cycle
        drive(1, IR_STORE, 1, 16'h0010, 16'hA5A5, 0, 0, 16'h0);
        step();
        check("store_we", 32'(d_we), 32'h1);
        check("store_dataout", 32'(d_dataout), 32'hA5A5);
        check("store_bubble", 32'(wb_valid), 32'h0);
        drive(1, IR_STORE, 1, 16'h0010, 16'hA5A5, 0, 1, 16'h1111);
        step();
        check("store_reg_C1", 32'(reg_C1), 32'hA5A5);
        check("store_wb_valid", 32'(wb_valid), 32'h1);

        // LOAD flushed in its second WAIT cycle
        drive(1, IR_LOAD, 1, 16'h0077, 16'h0, 0, 0, 16'h0);
        step();
        drive(1, IR_LOAD, 1, 16'h0077, 16'h0, 0, 0, 16'h0);
        step();
        drive(1, IR_LOAD, 1, 16'h0077, 16'h0, 1, 0, 16'h0);
        step();
        drive(1, IR_LOAD, 1, 16'h0077, 16'h0, 0, 0, 16'h0);
        step();
        check("flush_req_held", 32'(d_req), 32'h1);
        drive(1, IR_LOAD, 1, 16'h0077, 16'h0, 0, 1, 16'h9999);
        step();
        check("flush_wb_valid", 32'(wb_valid), 32'h0);
        check("flush_wb_ir", 32'(wb_ir), 32'h0);
        check("flush_reg_C1_held", 32'(reg_C1), 32'hA5A5);
        check("flush_req_drop", 32'(d_req), 32'h0);

        // Reset while WAITing, then state!=exec holds WB
        drive(1, IR_LOAD, 1, 16'h0033, 16'h0, 0, 0, 16'h0);
        step();
        drive(1, IR_LOAD, 1, 16'h0033, 16'h0, 0, 0, 16'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_wait_req", 32'(d_req), 32'h0);
        check("rst_wait_reg_C1", 32'(reg_C1), 32'h0);
        drive(1, IR_ADD, 1, 16'h7777, 16'h0, 0, 0, 16'h0);
        step();
        check("post_rst_add", 32'(wb_ir), 32'h0800);
        drive(0, 16'h1000, 1, 16'h5555, 16'h0, 0, 0, 16'h0);
        step();
        check("hold_wb_ir", 32'(wb_ir), 32'h0800);
        check("hold_reg_C1", 32'(reg_C1), 32'h7777);
        drive(0, IR_LOAD, 1, 16'h0021, 16'h0, 0, 0, 16'h0);
        #1 check("hold_no_stall", 32'(mem_stall), 32'h0);
        step();
        check("hold_no_req", 32'(d_req), 32'h0);

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after TO WAIT cycles
        drive(1, IR_LOAD, 1, 16'h0050, 16'h0, 0, 0, 16'h0);
        step();
        repeat (TO - 1) step();
        check("to_req_before", 32'(d_req), 32'h1);
        check("to_err_before", 32'(mem_err), 32'h0);
        step();
        check("to_req_drop", 32'(d_req), 32'h0);
        check("to_err_pulse", 32'(mem_err), 32'h1);
        check("to_wb_valid", 32'(wb_valid), 32'h0);
        drive(1, 16'h0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        step();
        check("to_err_clear", 32'(mem_err), 32'h0);
`endif

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom % 64 == 0);
            state     = ($urandom % 4 != 0);
            mem_valid = ($urandom % 4 != 0);
            flush     = ($urandom % 10 == 0);
            case ($urandom % 5)
                0:       op = 5'h08;
                1:       op = 5'h09;
                2:       op = 5'h01;
                default: op = 5'($urandom);
            endcase
            mem_ir   = {op, 11'($urandom)};
            reg_C    = 16'($urandom);
            st_data  = 16'($urandom);
            d_datain = 16'($urandom);
            if (m_busy) d_ack = (m_waited == ack_delay);
            else        d_ack = ($urandom % 6 == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
